systolic_tile_sequencer: RTL and testbench
==========================================

Name: systolic_tile_sequencer

Overview:
Sequencer placed in front of a ROWS x COLUMNS SystolicArray; runs one tile GEMM, C = A(ROWS x K) * B(K x COLUMNS), per Start.
- Accepts one A column and one B row per transfer through a joint valid/ready handshake.
- Clears the accumulators, then skews the lanes diagonally and drives the array edge ports.
- Tracks K and the drain latency, then pulses Done.
- Replaces hand-skewed bench/driver feeding; K is runtime-programmable.

Parameters:
ROWS, 4, array rows (weight lanes)
COLUMNS, 4, array columns (activation lanes)
INPUTS_N, 8, signed element width
MAX_K, 256, largest supported common dimension
PE_LATENCY, 1, cycles from PE operand arrival to updated accumulator
K_W, $clog2(MAX_K+1), derived width of K_Len and the K counter; not overridden

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  begin tile; sampled only in IDLE
K_Len  in  K_W  common dimension, sampled with Start
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle completion pulse
A_Col_Valid  in  1  A column available
A_Col_Ready  out  1  A column accepted
A_Col_Data  in  ROWS*INPUTS_N  A[r][k] in slice r
B_Row_Valid  in  1  B row available
B_Row_Ready  out  1  B row accepted
B_Row_Data  in  COLUMNS*INPUTS_N  B[k][c] in slice c
Weights_Out  out  ROWS*INPUTS_N  skewed weights to array left edge
Weight_Valids_Out  out  ROWS  per-lane weight valid
Acts_Out  out  COLUMNS*INPUTS_N  skewed activations to array top edge
Act_Valids_Out  out  COLUMNS  per-lane activation valid
Clear_Row_Out  out  ROWS  accumulator clear, row lanes
Clear_Column_Out  out  COLUMNS  accumulator clear, column lanes

Behaviour:
- Reset: all outputs 0, delay lines 0, counters 0, state IDLE. Reset asserted mid-tile aborts immediately; the partial tile is discarded.
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
  - IDLE: Start=1 latches K_Len. K_Len=0 goes to DONE; otherwise goes to CLEAR.
  - CLEAR: lasts 1 cycle; Clear_Row_Out and Clear_Column_Out are registered all-ones in the following cycle; then FEED.
  - FEED: k_cnt counts from 0 up to K_Len.
    - A_Col_Ready = FEED && k_cnt<K_Len && B_Row_Valid.
    - B_Row_Ready = FEED && k_cnt<K_Len && A_Col_Valid.
    - A transfer occurs only when both valids are high, so A and B are always consumed together; never singly.
    - The transfer that makes k_cnt reach K_Len loads drain_cnt=ROWS+COLUMNS+PE_LATENCY-1 and moves to DRAIN.
  - DRAIN: drain_cnt decrements every cycle; at 1, goes to DONE.
  - DONE: Done=1 for exactly one cycle, then IDLE.
- Start while Busy is ignored. Start and K_Len are ignored outside IDLE.
- Skew:
  - Weight lane r passes through r delay registers plus one output register.
  - Activation lane c passes through c delay registers plus one output register.
  - Every stage shifts every cycle. A non-transfer cycle injects valid=0 (a bubble) into all lanes at once, so diagonal alignment survives stalls.
  - Latency: a transfer at edge t drives lane r (or c) at edge t+1+r (or t+1+c).
  - Data registers hold their value when valid=0; downstream PEs gate on valid.
- K_Len > MAX_K is saturated to MAX_K.

Optional Feature:
SEQ_STALL_COUNT_EN
- Defined: adds port Stall_Count (out, 32 bits). It counts FEED cycles with k_cnt<K_Len and no transfer. It saturates at 2^32-1, clears on an accepted Start, and resets to 0.
- Undefined: no port and no counter logic.

Decomposition:
- Package systolic_pkg holds:
  - seq_state_t enum (IDLE, CLEAR, FEED, DRAIN, DONE);
  - function drain_cycles(rows, cols, pe_lat);
  - default width constants.
- Sub-module skew_delay_line (params DEPTH, WIDTH). It registers data plus valid, clears on Reset, and DEPTH=0 gives only the output register. It is instantiated once per lane via generate.

Test Plan:
- ROWS=COLUMNS=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], both valids held high from FEED entry (transfers at edges t0, t0+1):
  - Weights_Out lane0 = 1,2 at t0+1, t0+2.
  - Weights_Out lane1 = 3,4 at t0+2, t0+3.
  - Acts_Out lane0 = 5,7 at t0+1, t0+2; Acts_Out lane1 = 6,8 at t0+2, t0+3.
  - Done at t0+1+4; with the SystolicArray attached, C=[[19,22],[43,50]].
- Same matrices, B_Row_Valid dropped for 3 cycles between k=0 and k=1: one 3-cycle bubble appears in all lanes, skew offset is unchanged, C still [[19,22],[43,50]], Done 3 cycles later than the first test.
- Start with K_Len=0 -> no Clear pulse, no ready, Busy high for 1 cycle, Done 1 cycle after Start.
- Start pulsed during FEED with K_Len=7 -> ignored; the tile completes with the original K.
- Reset asserted in FEED after 1 of 4 transfers -> all outputs 0 at once, IDLE; the next Start with K=4 runs cleanly.
- With SEQ_STALL_COUNT_EN, the stalled test above -> Stall_Count=3; next Start -> 0.

Source files
------------

// File: rtl/systolic_tile_sequencer_pkg.sv
// Shared types and sizing helpers for the systolic tile sequencer slice.
package systolic_pkg;

  localparam int DEF_ROWS       = 4;
  localparam int DEF_COLUMNS    = 4;
  localparam int DEF_INPUTS_N   = 8;
  localparam int DEF_MAX_K      = 256;
  localparam int DEF_PE_LATENCY = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } seq_state_t;

  // Cycles after the last transfer until the far-corner PE holds its final sum.
  function automatic int drain_cycles(input int rows, input int cols, input int pe_lat);
    return rows + cols + pe_lat - 1;
  endfunction

endpackage

// File: rtl/systolic_tile_sequencer_if.sv
// Operand feed bus: one A column and one B row move together per transfer.
interface systolic_tile_sequencer_if
  import systolic_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLUMNS  = DEF_COLUMNS,
  parameter int INPUTS_N = DEF_INPUTS_N
);

  // A transfer happens on a rising edge where both valids are high and the
  // sequencer raises both readies; each ready already depends on the other
  // side's valid, so a column and a row are never consumed singly.
  logic                        A_Col_Valid;
  logic                        A_Col_Ready;
  logic [ROWS*INPUTS_N-1:0]    A_Col_Data;
  logic                        B_Row_Valid;
  logic                        B_Row_Ready;
  logic [COLUMNS*INPUTS_N-1:0] B_Row_Data;

  modport master (
    output A_Col_Valid, A_Col_Data, B_Row_Valid, B_Row_Data,
    input  A_Col_Ready, B_Row_Ready
  );

  modport slave (
    input  A_Col_Valid, A_Col_Data, B_Row_Valid, B_Row_Data,
    output A_Col_Ready, B_Row_Ready
  );

endinterface

// File: rtl/systolic_tile_sequencer_skew_delay_line.sv
// One skew lane: DEPTH delay stages plus an output register, data held while invalid.
module skew_delay_line #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             In_Valid,
  input  logic [WIDTH-1:0] In_Data,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Out_Data
);

  logic [DEPTH:0]   v_q;
  logic [WIDTH-1:0] d_q [DEPTH+1];

  // Stage DEPTH is the output register; valids always shift, data only moves with a valid.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      v_q <= '0;
      for (int i = 0; i <= DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= In_Valid;
      if (In_Valid) d_q[0] <= In_Data;
      for (int i = 1; i <= DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign Out_Valid = v_q[DEPTH];
  assign Out_Data  = d_q[DEPTH];

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Tile GEMM sequencer: clears, skews and feeds a systolic array, then signals Done.
// Optional macro SEQ_STALL_COUNT_EN adds the Stall_Count output.
module systolic_tile_sequencer
  import systolic_pkg::*;
#(
  parameter int  ROWS       = DEF_ROWS,
  parameter int  COLUMNS    = DEF_COLUMNS,
  parameter int  INPUTS_N   = DEF_INPUTS_N,
  parameter int  MAX_K      = DEF_MAX_K,
  parameter int  PE_LATENCY = DEF_PE_LATENCY,
  localparam int K_W        = $clog2(MAX_K + 1)
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic [K_W-1:0]              K_Len,
  output logic                        Busy,
  output logic                        Done,
  systolic_tile_sequencer_if.slave    feed,
  output logic [ROWS*INPUTS_N-1:0]    Weights_Out,
  output logic [ROWS-1:0]             Weight_Valids_Out,
  output logic [COLUMNS*INPUTS_N-1:0] Acts_Out,
  output logic [COLUMNS-1:0]          Act_Valids_Out,
  output logic [ROWS-1:0]             Clear_Row_Out,
  output logic [COLUMNS-1:0]          Clear_Column_Out,
  output seq_state_t                  Seq_State
`ifdef SEQ_STALL_COUNT_EN
  ,
  output logic [31:0]                 Stall_Count
`endif
);

  localparam int DRAIN_N = drain_cycles(ROWS, COLUMNS, PE_LATENCY);
  localparam int DRAIN_W = $clog2(DRAIN_N + 1);

  seq_state_t                  state_q, state_d;
  logic [K_W-1:0]              k_lat_q, k_cnt_q, k_sat;
  logic [DRAIN_W-1:0]          drain_cnt_q;
  logic                        start_acc, feeding, xfer, last_xfer;
  logic                        xfer_q, clear_q;
  logic [ROWS*INPUTS_N-1:0]    a_q;
  logic [COLUMNS*INPUTS_N-1:0] b_q;

  assign start_acc = (state_q == IDLE) && Start;
  assign k_sat     = (K_Len > K_W'(MAX_K)) ? K_W'(MAX_K) : K_Len;
  assign feeding   = (state_q == FEED) && (k_cnt_q < k_lat_q);
  assign xfer      = feeding && feed.A_Col_Valid && feed.B_Row_Valid;
  assign last_xfer = xfer && ((k_cnt_q + K_W'(1)) == k_lat_q);

  assign feed.A_Col_Ready = feeding && feed.B_Row_Valid;
  assign feed.B_Row_Ready = feeding && feed.A_Col_Valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = (K_Len == '0) ? DONE : CLEAR;
      CLEAR:   state_d = FEED;
      FEED:    if (last_xfer) state_d = DRAIN;
      DRAIN:   if (drain_cnt_q == DRAIN_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      k_lat_q     <= '0;
      k_cnt_q     <= '0;
      drain_cnt_q <= '0;
      clear_q     <= 1'b0;
      xfer_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      state_q <= state_d;
      clear_q <= (state_q == CLEAR);
      if (start_acc) begin
        k_lat_q <= k_sat;
        k_cnt_q <= '0;
      end else if (xfer) begin
        k_cnt_q <= k_cnt_q + K_W'(1);
      end
      if (last_xfer) drain_cnt_q <= DRAIN_W'(DRAIN_N);
      else if (state_q == DRAIN) drain_cnt_q <= drain_cnt_q - DRAIN_W'(1);
      // Non-transfer cycles enter every lane as a bubble, keeping the diagonal intact.
      xfer_q <= xfer;
      if (xfer) begin
        a_q <= feed.A_Col_Data;
        b_q <= feed.B_Row_Data;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_weight_lane
    skew_delay_line #(.DEPTH(r), .WIDTH(INPUTS_N)) u_lane (
      .Clock     (Clock),
      .Reset     (Reset),
      .In_Valid  (xfer_q),
      .In_Data   (a_q[r*INPUTS_N +: INPUTS_N]),
      .Out_Valid (Weight_Valids_Out[r]),
      .Out_Data  (Weights_Out[r*INPUTS_N +: INPUTS_N])
    );
  end

  for (genvar c = 0; c < COLUMNS; c++) begin : g_act_lane
    skew_delay_line #(.DEPTH(c), .WIDTH(INPUTS_N)) u_lane (
      .Clock     (Clock),
      .Reset     (Reset),
      .In_Valid  (xfer_q),
      .In_Data   (b_q[c*INPUTS_N +: INPUTS_N]),
      .Out_Valid (Act_Valids_Out[c]),
      .Out_Data  (Acts_Out[c*INPUTS_N +: INPUTS_N])
    );
  end

  assign Clear_Row_Out    = {ROWS{clear_q}};
  assign Clear_Column_Out = {COLUMNS{clear_q}};
  assign Busy             = (state_q != IDLE);
  assign Done             = (state_q == DONE);
  assign Seq_State        = state_q;

`ifdef SEQ_STALL_COUNT_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Stall_Count <= '0;
    end else if (start_acc) begin
      Stall_Count <= '0;
    end else if (feeding && !xfer && (Stall_Count != 32'hFFFF_FFFF)) begin
      Stall_Count <= Stall_Count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Directed bench for systolic_tile_sequencer on a 2x2 array with a small reference PE grid.
module tb_systolic_tile_sequencer;
  import systolic_pkg::*;

  localparam int R  = 2;
  localparam int C  = 2;
  localparam int N  = 8;
  localparam int KW = $clog2(DEF_MAX_K + 1);

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic [KW-1:0] K_Len = '0;
  logic          Busy, Done;
  logic [R*N-1:0] Weights_Out;
  logic [R-1:0]   Weight_Valids_Out, Clear_Row_Out;
  logic [C*N-1:0] Acts_Out;
  logic [C-1:0]   Act_Valids_Out, Clear_Column_Out;
  seq_state_t     Seq_State;
`ifdef SEQ_STALL_COUNT_EN
  logic [31:0]    Stall_Count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [7:0] a_m [2][4];
  logic [7:0] b_m [4][2];

  systolic_tile_sequencer_if #(.ROWS(R), .COLUMNS(C), .INPUTS_N(N)) feed_if ();

  systolic_tile_sequencer #(.ROWS(R), .COLUMNS(C), .INPUTS_N(N)) dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .Start             (Start),
    .K_Len             (K_Len),
    .Busy              (Busy),
    .Done              (Done),
    .feed              (feed_if),
    .Weights_Out       (Weights_Out),
    .Weight_Valids_Out (Weight_Valids_Out),
    .Acts_Out          (Acts_Out),
    .Act_Valids_Out    (Act_Valids_Out),
    .Clear_Row_Out     (Clear_Row_Out),
    .Clear_Column_Out  (Clear_Column_Out),
    .Seq_State         (Seq_State)
`ifdef SEQ_STALL_COUNT_EN
    ,
    .Stall_Count       (Stall_Count)
`endif
  );

  // Clock and cycle counter
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Reference output-stationary 2x2 array, sampled on the falling edge.
  logic [7:0] mw [2][2], ma [2][2];
  logic       mwv [2][2], mav [2][2];
  int         acc [2][2];

  always @(negedge Clock) begin
    logic [7:0] nw [2][2], na [2][2];
    logic       nwv [2][2], nav [2][2];
    if (Reset) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          mw[r][c] = '0; ma[r][c] = '0; mwv[r][c] = 1'b0; mav[r][c] = 1'b0; acc[r][c] = 0;
        end
    end else begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          nw[r][c]  = (c == 0) ? Weights_Out[r*N +: N] : mw[r][c-1];
          nwv[r][c] = (c == 0) ? Weight_Valids_Out[r] : mwv[r][c-1];
          na[r][c]  = (r == 0) ? Acts_Out[c*N +: N] : ma[r-1][c];
          nav[r][c] = (r == 0) ? Act_Valids_Out[c] : mav[r-1][c];
          if (Clear_Row_Out[r] && Clear_Column_Out[c]) acc[r][c] = 0;
          else if (nwv[r][c] && nav[r][c])
            acc[r][c] = acc[r][c] + int'($signed(nw[r][c])) * int'($signed(na[r][c]));
        end
      mw = nw; ma = na; mwv = nwv; mav = nav;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_k(input int k);
    feed_if.A_Col_Data  = {a_m[1][k], a_m[0][k]};
    feed_if.B_Row_Data  = {b_m[k][1], b_m[k][0]};
    feed_if.A_Col_Valid = 1'b1;
    feed_if.B_Row_Valid = 1'b1;
    #1;
  endtask

  task automatic idle_bus();
    feed_if.A_Col_Valid = 1'b0;
    feed_if.B_Row_Valid = 1'b0;
    #1;
  endtask

  task automatic start_tile(input int k);
    Start = 1'b1;
    K_Len = KW'(k);
    tick();
    Start = 1'b0;
    K_Len = '0;
    start_cyc = cyc;
  endtask

  task automatic feed_all(input int k_len);
    int n;
    for (int k = 0; k < k_len; k++) begin
      drive_k(k);
      n = 0;
      while (feed_if.A_Col_Ready !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("feed_ready", feed_if.A_Col_Ready, 1);
      tick();
    end
    idle_bus();
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (Done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, Done, 1);
    chk({tag, "_lat"}, cyc - start_cyc, exp_lat);
  endtask

  task automatic check_c(input string tag, input int c00, input int c01, input int c10, input int c11);
    chk({tag, "_c00"}, acc[0][0], c00);
    chk({tag, "_c01"}, acc[0][1], c01);
    chk({tag, "_c10"}, acc[1][0], c10);
    chk({tag, "_c11"}, acc[1][1], c11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    feed_if.A_Col_Valid = 1'b0;
    feed_if.B_Row_Valid = 1'b0;
    feed_if.A_Col_Data  = '0;
    feed_if.B_Row_Data  = '0;
    a_m = '{'{8'd1, 8'd2, 8'd0, 8'd0}, '{8'd3, 8'd4, 8'd0, 8'd0}};
    b_m = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}, '{8'd0, 8'd0}, '{8'd0, 8'd0}};
    #2 Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();

    // Reset state
    chk("rst_state", Seq_State, IDLE);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_w", {Weight_Valids_Out, Weights_Out}, 0);
    chk("rst_a", {Act_Valids_Out, Acts_Out}, 0);
    chk("rst_clr", {Clear_Row_Out, Clear_Column_Out}, 0);
    chk("rst_rdy", {feed_if.A_Col_Ready, feed_if.B_Row_Ready}, 0);

    // Test 1: K=2, valids held high from FEED entry
    start_tile(2);
    chk("t1_busy", Busy, 1);
    chk("t1_state", Seq_State, CLEAR);
    chk("t1_clr_early", {Clear_Row_Out, Clear_Column_Out}, 0);
    drive_k(0);
    chk("t1_rdy_clear", {feed_if.A_Col_Ready, feed_if.B_Row_Ready}, 0);
    tick();
    chk("t1_clr", {Clear_Row_Out, Clear_Column_Out}, 4'hF);
    chk("t1_rdy_feed", {feed_if.A_Col_Ready, feed_if.B_Row_Ready}, 2'b11);
    tick();
    drive_k(1);
    chk("t1_clr_off", {Clear_Row_Out, Clear_Column_Out}, 0);
    chk("t1_wv_t0", Weight_Valids_Out, 0);
    tick();
    idle_bus();
    chk("t1_state_drain", Seq_State, DRAIN);
    chk("t1_w_t1", {Weight_Valids_Out, Weights_Out}, {2'b01, 16'h0001});
    chk("t1_a_t1", {Act_Valids_Out, Acts_Out}, {2'b01, 16'h0005});
    tick();
    chk("t1_w_t2", {Weight_Valids_Out, Weights_Out}, {2'b11, 16'h0302});
    chk("t1_a_t2", {Act_Valids_Out, Acts_Out}, {2'b11, 16'h0607});
    tick();
    chk("t1_w_t3", {Weight_Valids_Out, Weights_Out}, {2'b10, 16'h0402});
    chk("t1_a_t3", {Act_Valids_Out, Acts_Out}, {2'b10, 16'h0807});
    wait_done("t1", 7);
    tick();
    chk("t1_done_pulse", {Done, Busy}, 2'b00);
    check_c("t1", 19, 22, 43, 50);

    // Test 2: B_Row_Valid dropped for three cycles between k=0 and k=1
    start_tile(2);
    drive_k(0);
    tick();
    tick();
    feed_if.B_Row_Valid = 1'b0;
    #1;
    chk("t2_rdy_stall", {feed_if.A_Col_Ready, feed_if.B_Row_Ready}, 2'b01);
    tick();
    chk("t2_wv_1", Weight_Valids_Out, 2'b01);
    tick();
    chk("t2_wv_2", Weight_Valids_Out, 2'b10);
    tick();
    chk("t2_wv_3", {Weight_Valids_Out, Act_Valids_Out}, 4'b0000);
    drive_k(1);
    tick();
    idle_bus();
    chk("t2_wv_4", Weight_Valids_Out, 2'b00);
    tick();
    chk("t2_w_5", {Weight_Valids_Out, Weights_Out}, {2'b01, 16'h0302});
    chk("t2_a_5", {Act_Valids_Out, Acts_Out}, {2'b01, 16'h0607});
    wait_done("t2", 10);
    check_c("t2", 19, 22, 43, 50);
`ifdef SEQ_STALL_COUNT_EN
    chk("t2_stall_count", Stall_Count, 3);
`endif
    tick();

    // Test 3: K_Len=0 completes without clearing or feeding
    drive_k(0);
    start_tile(0);
    chk("t3_busy", Busy, 1);
    chk("t3_state", Seq_State, DONE);
    chk("t3_clr", {Clear_Row_Out, Clear_Column_Out}, 0);
    chk("t3_rdy", {feed_if.A_Col_Ready, feed_if.B_Row_Ready}, 0);
    wait_done("t3", 0);
`ifdef SEQ_STALL_COUNT_EN
    chk("t3_stall_cleared", Stall_Count, 0);
`endif
    tick();
    chk("t3_after", {Busy, Done, Clear_Row_Out}, 0);
    idle_bus();

    // Test 4: Start with K_Len=7 during FEED is ignored
    start_tile(2);
    tick();
    Start = 1'b1;
    K_Len = KW'(7);
    tick();
    Start = 1'b0;
    K_Len = '0;
    chk("t4_state_feed", Seq_State, FEED);
    feed_all(2);
    chk("t4_state_drain", Seq_State, DRAIN);
    wait_done("t4", 8);
    check_c("t4", 19, 22, 43, 50);
    tick();

    // Test 5: reset after one of four transfers, then a clean K=4 tile
    a_m = '{'{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd1, 8'd1, 8'd1, 8'd1}};
    b_m = '{'{8'd1, 8'd0}, '{8'd0, 8'd1}, '{8'd1, 8'd1}, '{8'd2, 8'hFF}};
    start_tile(4);
    tick();
    drive_k(0);
    tick();
    idle_bus();
    tick();
    chk("t5_pre_wv", Weight_Valids_Out, 2'b01);
    drive_k(1);
    Reset = 1'b1;
    #1;
    chk("t5_rst_state", Seq_State, IDLE);
    chk("t5_rst_busy", {Busy, Done}, 0);
    chk("t5_rst_w", {Weight_Valids_Out, Weights_Out}, 0);
    chk("t5_rst_a", {Act_Valids_Out, Acts_Out}, 0);
    chk("t5_rst_rdy", {feed_if.A_Col_Ready, feed_if.B_Row_Ready}, 0);
    tick();
    Reset = 1'b0;
    idle_bus();
    tick();
    start_tile(4);
    feed_all(4);
    wait_done("t5", 9);
    check_c("t5", 12, 1, 4, 1);
    tick();
    chk("t5_idle", Seq_State, IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
